pipe_arith_arbiter: RTL



---
 rtl/pipe_arith_arbiter_if.sv | 51 +++++
 rtl/pipe_arith_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipe_arith_arbiter_if.sv
// ---------------------------------------------------------------------------
// pipe_arith_arbiter_if
// Bundles every signal exchanged between the shared arithmetic pipeline and
// the outside world: the global stall, both request ports and the tagged
// result stream.
//   stall                  : freezes the pipeline and blocks new accepts
//   reqX_valid / reqX_ready: valid/ready handshake for requester X (0 or 1)
//   reqX_a..reqX_d         : operands of requester X, N bits each
//   res_valid/res_id/res_data : result pulse, owning requester, value F
//   in_flight              : number of occupied pipeline stages (0..3)
//   idle                   : pipeline empty and no request pending
// Modports: slave = the arbiter/pipeline block, master = clients/environment.
// ---------------------------------------------------------------------------
interface pipe_arith_arbiter_if #(
    parameter int N = 10
);
    logic         stall;
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [N-1:0] req0_c;
    logic [N-1:0] req0_d;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [N-1:0] req1_c;
    logic [N-1:0] req1_d;
    logic         res_valid;
    logic         res_id;
    logic [N-1:0] res_data;
    logic [1:0]   in_flight;
    logic         idle;

    modport slave (
        input  stall,
        input  req0_valid, req0_a, req0_b, req0_c, req0_d,
        input  req1_valid, req1_a, req1_b, req1_c, req1_d,
        output req0_ready, req1_ready,
        output res_valid, res_id, res_data, in_flight, idle
    );

    modport master (
        output stall,
        output req0_valid, req0_a, req0_b, req0_c, req0_d,
        output req1_valid, req1_a, req1_b, req1_c, req1_d,
        input  req0_ready, req1_ready,
        input  res_valid, res_id, res_data, in_flight, idle
    );
endinterface

// File: rtl/pipe_arith_arbiter.sv
// ---------------------------------------------------------------------------
// pipe_arith_arbiter
// Round-robin arbiter in front of a 3-stage pipeline computing
//   F = ((A+B)+(C-D))*D   (all arithmetic modulo 2^N)
// Each operation carries the ID of the requester that issued it, so results
// come back tagged. A global stall freezes every stage.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (wins over stall)
//   bus : pipe_arith_arbiter_if.slave, carrying stall, both request ports,
//         the tagged result stream, in_flight and idle
// ---------------------------------------------------------------------------
module pipe_arith_arbiter #(
    parameter int N = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_arith_arbiter_if.slave    bus
);

    // Round-robin pointer: ID of the requester that was accepted most recently.
    logic         last_grant_q, last_grant_d;

    // Stage 1: partial sums, operand D, valid and tag.
    logic [N-1:0] x1_q, x1_d;
    logic [N-1:0] x2_q, x2_d;
    logic [N-1:0] d1_q, d1_d;
    logic         v1_q, v1_d;
    logic         t1_q, t1_d;

    // Stage 2: combined sum, operand D, valid and tag.
    logic [N-1:0] x3_q, x3_d;
    logic [N-1:0] d2_q, d2_d;
    logic         v2_q, v2_d;
    logic         t2_q, t2_d;

    // Stage 3: truncated product, valid and tag.
    logic [N-1:0] f3_q, f3_d;
    logic         v3_q, v3_d;
    logic         t3_q, t3_d;

    logic         any_req;
    logic         grant_id;
    logic         accept;
    logic [N-1:0] op_a, op_b, op_c, op_d;

    // Arbitration: a lone requester always wins; on a conflict the requester
    // that was not granted last time wins. Because the winner is always a
    // valid requester, any request while not stalled is an accept.
    always_comb begin
        any_req  = bus.req0_valid | bus.req1_valid;
        grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
        accept = any_req & ~bus.stall;

        op_a = bus.req0_a;
        op_b = bus.req0_b;
        op_c = bus.req0_c;
        op_d = bus.req0_d;
        if (grant_id) begin
            op_a = bus.req1_a;
            op_b = bus.req1_b;
            op_c = bus.req1_c;
            op_d = bus.req1_d;
        end
    end

    // Next-state logic: everything holds under stall. On advance the data
    // registers load unconditionally; only the valid bits say whether the
    // stage content means anything.
    always_comb begin
        last_grant_d = last_grant_q;
        x1_d = x1_q;
        x2_d = x2_q;
        d1_d = d1_q;
        v1_d = v1_q;
        t1_d = t1_q;
        x3_d = x3_q;
        d2_d = d2_q;
        v2_d = v2_q;
        t2_d = t2_q;
        f3_d = f3_q;
        v3_d = v3_q;
        t3_d = t3_q;

        if (!bus.stall) begin
            if (accept) begin
                last_grant_d = grant_id;
            end
            x1_d = op_a + op_b;
            x2_d = op_c - op_d;
            d1_d = op_d;
            v1_d = accept;
            t1_d = grant_id;

            x3_d = x1_q + x2_q;
            d2_d = d1_q;
            v2_d = v1_q;
            t2_d = t1_q;

            // N-bit operands into an N-bit target keep only the low N bits
            // of the product.
            f3_d = x3_q * d2_q;
            v3_d = v2_q;
            t3_d = t2_q;
        end
    end

    // State registers; the pointer resets to 1 so requester 0 wins the first
    // conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            x1_q <= '0;
            x2_q <= '0;
            d1_q <= '0;
            v1_q <= 1'b0;
            t1_q <= 1'b0;
            x3_q <= '0;
            d2_q <= '0;
            v2_q <= 1'b0;
            t2_q <= 1'b0;
            f3_q <= '0;
            v3_q <= 1'b0;
            t3_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            x1_q <= x1_d;
            x2_q <= x2_d;
            d1_q <= d1_d;
            v1_q <= v1_d;
            t1_q <= t1_d;
            x3_q <= x3_d;
            d2_q <= d2_d;
            v2_q <= v2_d;
            t2_q <= t2_d;
            f3_q <= f3_d;
            v3_q <= v3_d;
            t3_q <= t3_d;
        end
    end

    assign bus.req0_ready = any_req & ~grant_id & ~bus.stall;
    assign bus.req1_ready = any_req &  grant_id & ~bus.stall;

    // A result held in stage 3 during a stall is masked here and shows up
    // once, in the first unstalled cycle.
    assign bus.res_valid = v3_q & ~bus.stall;
    assign bus.res_id    = t3_q;
    assign bus.res_data  = f3_q;

    assign bus.in_flight = {1'b0, v1_q} + {1'b0, v2_q} + {1'b0, v3_q};
    assign bus.idle      = ~(v1_q | v2_q | v3_q) & ~bus.req0_valid & ~bus.req1_valid;

endmodule
